// File: rtl/shell_scheduler.sv
// Shared projectile-slot scheduler for the two-player tank game: grants fire
// requests into a fixed shell pool, moves live shells each frame and retires them.
module shell_scheduler #(
    parameter int NUM_SLOTS  = 4,
    parameter int SHELL_STEP = 4,
    parameter int COOLDOWN   = 30,
    parameter int PLAYER_CAP = 2,
    parameter int X_MIN      = 1,
    parameter int X_MAX      = 639,
    parameter int Y_MIN      = 1,
    parameter int Y_MAX      = 479
) (
    input  logic                      frame_clk,
    input  logic                      Reset_n,
    input  logic [1:0]                fire_req,
    input  logic [9:0]                p1_x,
    input  logic [9:0]                p1_y,
    input  logic [1:0]                p1_dir,
    input  logic [9:0]                p2_x,
    input  logic [9:0]                p2_y,
    input  logic [1:0]                p2_dir,
    input  logic [NUM_SLOTS-1:0]      hit_clear,
    output logic [1:0]                fire_ack,
    output logic [NUM_SLOTS-1:0]      slot_valid,
    output logic [NUM_SLOTS-1:0]      slot_owner,
    output logic [2*NUM_SLOTS-1:0]    slot_dir,
    output logic [10*NUM_SLOTS-1:0]   slot_x,
    output logic [10*NUM_SLOTS-1:0]   slot_y,
    output logic [1:0]                cooldown_active
);
    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef logic [IW-1:0] idx_t;

    logic [NUM_SLOTS-1:0]    valid_q, valid_d;
    logic [NUM_SLOTS-1:0]    owner_q, owner_d;
    logic [2*NUM_SLOTS-1:0]  dir_q, dir_d;
    logic [10*NUM_SLOTS-1:0] x_q, x_d;
    logic [10*NUM_SLOTS-1:0] y_q, y_d;
    logic [1:0]              ack_q, ack_d;
    logic [1:0][CW-1:0]      cd_q, cd_d;
    logic [1:0]              cd_act_q, cd_act_d;
    logic                    rr_q, rr_d;

    logic [1:0][7:0]         live_cnt_s;
    logic [1:0]              elig_s;
    logic [1:0]              grant_s;
    logic [1:0][IW-1:0]      gslot_s;
    idx_t                    first_s, second_s;
    logic                    has_first_s, has_second_s;
    logic [1:0][9:0]         tank_x_s, tank_y_s;
    logic [1:0][1:0]         tank_dir_s;

    assign tank_x_s   = {p2_x, p1_x};
    assign tank_y_s   = {p2_y, p1_y};
    assign tank_dir_s = {p2_dir, p1_dir};

    // Bounds are checked on the unmoved position so a shell never wraps through 0 or 1023.
    function automatic logic leaves_bounds(input logic [1:0] dir, input logic [9:0] x,
                                           input logic [9:0] y);
        logic r;
        case (dir)
            2'b00:   r = ({1'b0, x} < 11'(X_MIN + SHELL_STEP));
            2'b01:   r = (({1'b0, x} + 11'(SHELL_STEP)) > 11'(X_MAX));
            2'b10:   r = (({1'b0, y} + 11'(SHELL_STEP)) > 11'(Y_MAX));
            2'b11:   r = ({1'b0, y} < 11'(Y_MIN + SHELL_STEP));
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [19:0] step_pos(input logic [1:0] dir, input logic [9:0] x,
                                             input logic [9:0] y);
        logic [9:0] nx;
        logic [9:0] ny;
        nx = x;
        ny = y;
        case (dir)
            2'b00:   nx = x - 10'(SHELL_STEP);
            2'b01:   nx = x + 10'(SHELL_STEP);
            2'b10:   ny = y + 10'(SHELL_STEP);
            2'b11:   ny = y - 10'(SHELL_STEP);
            default: begin
                nx = x;
                ny = y;
            end
        endcase
        return {nx, ny};
    endfunction

    // Live shell count per player and fire eligibility, all from pre-edge state.
    always_comb begin
        live_cnt_s = '0;
        elig_s     = 2'b00;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            live_cnt_s[0] = live_cnt_s[0] + {7'd0, valid_q[i] & ~owner_q[i]};
            live_cnt_s[1] = live_cnt_s[1] + {7'd0, valid_q[i] & owner_q[i]};
        end
        for (int p = 0; p < 2; p++) begin
            elig_s[p] = fire_req[p] & (cd_q[p] == '0) & (live_cnt_s[p] < 8'(PLAYER_CAP));
        end
    end

    // Lowest and second-lowest free slot; slots retiring this edge still count as busy.
    always_comb begin
        has_first_s  = 1'b0;
        has_second_s = 1'b0;
        first_s      = '0;
        second_s     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!valid_q[i] && !has_first_s) begin
                first_s     = idx_t'(i);
                has_first_s = 1'b1;
            end else if (!valid_q[i] && !has_second_s) begin
                second_s     = idx_t'(i);
                has_second_s = 1'b1;
            end else begin
                has_second_s = has_second_s | (has_first_s & ~valid_q[i]);
            end
        end
    end

    // Slot allocation and round-robin pointer (0 = P1 has priority on a single free slot).
    always_comb begin
        grant_s    = 2'b00;
        gslot_s[0] = first_s;
        gslot_s[1] = first_s;
        rr_d       = rr_q;
        case (elig_s)
            2'b11: begin
                if (has_second_s) begin
                    grant_s    = 2'b11;
                    gslot_s[1] = second_s;
                end else if (has_first_s) begin
                    grant_s = rr_q ? 2'b10 : 2'b01;
                    rr_d    = ~rr_q;
                end else begin
                    grant_s = 2'b00;
                end
            end
            2'b01: begin
                grant_s = {1'b0, has_first_s};
                rr_d    = has_first_s ? 1'b1 : rr_q;
            end
            2'b10: begin
                grant_s = {has_first_s, 1'b0};
                rr_d    = has_first_s ? 1'b0 : rr_q;
            end
            default: begin
                grant_s = 2'b00;
            end
        endcase
    end

    // Per-slot retire/move, then load newly granted slots (always free pre-edge, so no overlap).
    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        dir_d   = dir_q;
        x_d     = x_q;
        y_d     = y_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (valid_q[i] && hit_clear[i]) begin
                valid_d[i] = 1'b0;
            end else if (valid_q[i] && leaves_bounds(dir_q[2*i +: 2], x_q[10*i +: 10], y_q[10*i +: 10])) begin
                valid_d[i] = 1'b0;
            end else if (valid_q[i]) begin
                {x_d[10*i +: 10], y_d[10*i +: 10]} = step_pos(dir_q[2*i +: 2], x_q[10*i +: 10], y_q[10*i +: 10]);
            end else begin
                valid_d[i] = 1'b0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (grant_s[p]) begin
                valid_d[gslot_s[p]]         = 1'b1;
                owner_d[gslot_s[p]]         = 1'(p);
                dir_d[2*gslot_s[p] +: 2]    = tank_dir_s[p];
                x_d[10*gslot_s[p] +: 10]    = tank_x_s[p];
                y_d[10*gslot_s[p] +: 10]    = tank_y_s[p];
            end else begin
                owner_d = owner_d;
            end
        end
    end

    // Cooldown counters: reload on grant, otherwise count down and stick at zero.
    always_comb begin
        cd_d     = cd_q;
        cd_act_d = 2'b00;
        ack_d    = grant_s;
        for (int p = 0; p < 2; p++) begin
            if (grant_s[p]) begin
                cd_d[p] = CW'(COOLDOWN);
            end else if (cd_q[p] != '0) begin
                cd_d[p] = cd_q[p] - CW'(1);
            end else begin
                cd_d[p] = '0;
            end
            cd_act_d[p] = (cd_d[p] != '0);
        end
    end

    // State register; reset clears the pool, counters, acks and points RR at P1.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q  <= '0;
            owner_q  <= '0;
            dir_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            ack_q    <= 2'b00;
            cd_q     <= '0;
            cd_act_q <= 2'b00;
            rr_q     <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            owner_q  <= owner_d;
            dir_q    <= dir_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ack_q    <= ack_d;
            cd_q     <= cd_d;
            cd_act_q <= cd_act_d;
            rr_q     <= rr_d;
        end
    end

    assign fire_ack        = ack_q;
    assign slot_valid      = valid_q;
    assign slot_owner      = owner_q;
    assign slot_dir        = dir_q;
    assign slot_x          = x_q;
    assign slot_y          = y_q;
    assign cooldown_active = cd_act_q;

endmodule

// File: tb/tb_shell_scheduler.sv
// Directed bench for shell_scheduler: grants are pushed to a scoreboard when
// requested and checked when fire_ack appears; a cap-3 instance covers contention.
module tb_shell_scheduler;
    localparam int N = 4;

    logic            frame_clk = 1'b0;
    logic            Reset_n   = 1'b0;
    logic [1:0]      fire_req  = 2'b00;
    logic [9:0]      p1_x = 10'd0, p1_y = 10'd0, p2_x = 10'd0, p2_y = 10'd0;
    logic [1:0]      p1_dir = 2'b00, p2_dir = 2'b00;
    logic [N-1:0]    hit_clear = '0;

    logic [1:0]      fire_ack, cooldown_active;
    logic [N-1:0]    slot_valid, slot_owner;
    logic [2*N-1:0]  slot_dir;
    logic [10*N-1:0] slot_x, slot_y;

    logic [1:0]      c_fire_ack, c_cooldown_active;
    logic [N-1:0]    c_slot_valid, c_slot_owner;
    logic [2*N-1:0]  c_slot_dir;
    logic [10*N-1:0] c_slot_x, c_slot_y;

    shell_scheduler dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .fire_req(fire_req),
        .p1_x(p1_x), .p1_y(p1_y), .p1_dir(p1_dir),
        .p2_x(p2_x), .p2_y(p2_y), .p2_dir(p2_dir),
        .hit_clear(hit_clear), .fire_ack(fire_ack), .slot_valid(slot_valid),
        .slot_owner(slot_owner), .slot_dir(slot_dir), .slot_x(slot_x),
        .slot_y(slot_y), .cooldown_active(cooldown_active)
    );

    shell_scheduler #(.PLAYER_CAP(3), .COOLDOWN(2)) dut3 (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .fire_req(fire_req),
        .p1_x(p1_x), .p1_y(p1_y), .p1_dir(p1_dir),
        .p2_x(p2_x), .p2_y(p2_y), .p2_dir(p2_dir),
        .hit_clear(hit_clear), .fire_ack(c_fire_ack), .slot_valid(c_slot_valid),
        .slot_owner(c_slot_owner), .slot_dir(c_slot_dir), .slot_x(c_slot_x),
        .slot_y(c_slot_y), .cooldown_active(c_cooldown_active)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int player;
        int slot;
        int x;
        int y;
        int dir;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   sb_on = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] sx(input int i);
        return slot_x[10*i +: 10];
    endfunction

    function automatic logic [9:0] sy(input int i);
        return slot_y[10*i +: 10];
    endfunction

    task automatic exp_grant(input int p, input int s, input int x, input int y, input int d);
        exp_t e;
        e.player = p;
        e.slot   = s;
        e.x      = x;
        e.y      = y;
        e.dir    = d;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
        if (sb_on) begin
            for (int p = 0; p < 2; p++) begin
                if (fire_ack[p]) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_ack", 64'(p), 64'd99);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("sb_player", 64'(p), 64'(e.player));
                        chk("sb_valid", slot_valid[e.slot], 1);
                        chk("sb_owner", slot_owner[e.slot], 64'(e.player));
                        chk("sb_dir", slot_dir[2*e.slot +: 2], 64'(e.dir));
                        chk("sb_x", sx(e.slot), 64'(e.x));
                        chk("sb_y", sy(e.slot), 64'(e.y));
                    end
                end
            end
        end
    endtask

    task automatic reset_pulse();
        fire_req  = 2'b00;
        hit_clear = '0;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rst_valid", slot_valid, 0);
        chk("rst_ack", fire_ack, 0);
        chk("rst_cd", cooldown_active, 0);
        chk("rst_x", slot_x, 0);
        chk("rst_y", slot_y, 0);
        chk("rst_c_valid", c_slot_valid, 0);
        sb_q.delete();
        @(posedge frame_clk);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacks;
        int g0;
        int g1;

        // Basic grant, one-cycle ack and movement to the right.
        reset_pulse();
        p1_x = 10'd160; p1_y = 10'd240; p1_dir = 2'b01;
        fire_req = 2'b01;
        exp_grant(0, 0, 160, 240, 1);
        tick();
        chk("t1_ack", fire_ack, 2'b01);
        chk("t1_valid", slot_valid, 4'b0001);
        chk("t1_cd", cooldown_active, 2'b01);
        fire_req = 2'b00;
        tick();
        chk("t1_ack_pulse", fire_ack, 2'b00);
        chk("t1_x1", sx(0), 164);
        repeat (4) tick();
        chk("t1_x5", sx(0), 180);
        chk("t1_y5", sy(0), 240);

        // Held request: grants on frames 0 and 31, then the cap blocks until a retire.
        reset_pulse();
        p1_x = 10'd100; p1_y = 10'd100; p1_dir = 2'b01;
        exp_grant(0, 0, 100, 100, 1);
        exp_grant(0, 1, 100, 100, 1);
        fire_req = 2'b01;
        nacks = 0; g0 = -1; g1 = -1;
        for (int f = 0; f < 100; f++) begin
            tick();
            if (fire_ack[0]) begin
                if (nacks == 0) g0 = f;
                else if (nacks == 1) g1 = f;
                nacks++;
            end
        end
        chk("t2_nacks", 64'(nacks), 2);
        chk("t2_first", 64'(g0), 0);
        chk("t2_second", 64'(g1), 31);
        chk("t2_sb_empty", 64'(sb_q.size()), 0);
        chk("t2_x0", sx(0), 496);
        hit_clear = 4'b0001;
        tick();
        chk("t2_no_same_edge", fire_ack, 2'b00);
        chk("t2_valid_hit", slot_valid, 4'b0010);
        hit_clear = '0;
        p1_x = 10'd200; p1_y = 10'd50;
        exp_grant(0, 0, 200, 50, 1);
        tick();
        chk("t2_third_ack", fire_ack, 2'b01);
        chk("t2_valid_third", slot_valid, 4'b0011);
        fire_req = 2'b00;
        chk("t2_sb_done", 64'(sb_q.size()), 0);

        // Bounds: left shell at x=4 retires in place, down shell at y=475 reaches 479 then retires.
        reset_pulse();
        p1_x = 10'd4;   p1_y = 10'd100; p1_dir = 2'b00;
        p2_x = 10'd300; p2_y = 10'd475; p2_dir = 2'b10;
        exp_grant(0, 0, 4, 100, 0);
        exp_grant(1, 1, 300, 475, 2);
        fire_req = 2'b11;
        tick();
        chk("t4_ack", fire_ack, 2'b11);
        fire_req = 2'b00;
        tick();
        chk("t4_valid1", slot_valid, 4'b0010);
        chk("t4_x_held", sx(0), 4);
        chk("t4_y_479", sy(1), 479);
        tick();
        chk("t4_valid2", slot_valid, 4'b0000);
        chk("t4_y_held", sy(1), 479);

        // Single-free-slot contention on the cap-3 instance.
        sb_on = 1'b0;
        reset_pulse();
        p1_x = 10'd300; p1_y = 10'd200; p1_dir = 2'b01;
        p2_x = 10'd300; p2_y = 10'd300; p2_dir = 2'b00;
        fire_req = 2'b11;
        tick();
        chk("t3_ack_both", c_fire_ack, 2'b11);
        chk("t3_owner01", c_slot_owner[1:0], 2'b10);
        fire_req = 2'b00;
        tick();
        tick();
        fire_req = 2'b10;
        tick();
        chk("t3_ack_p2", c_fire_ack, 2'b10);
        chk("t3_valid3", c_slot_valid, 4'b0111);
        chk("t3_owner2", c_slot_owner[2], 1'b1);
        fire_req = 2'b00;
        tick();
        tick();
        fire_req = 2'b11;
        tick();
        chk("t3_rr_p1", c_fire_ack, 2'b01);
        chk("t3_valid4", c_slot_valid, 4'b1111);
        chk("t3_owner3", c_slot_owner[3], 1'b0);
        fire_req  = 2'b00;
        hit_clear = 4'b0001;
        tick();
        chk("t3_freed", c_slot_valid, 4'b1110);
        hit_clear = '0;
        tick();
        fire_req = 2'b11;
        tick();
        chk("t3_rr_p2", c_fire_ack, 2'b10);
        chk("t3_valid_again", c_slot_valid, 4'b1111);
        chk("t3_owner0", c_slot_owner[0], 1'b1);
        fire_req = 2'b00;
        sb_on = 1'b1;

        // Full pool; hit on slot1 while P2 requests is reused only on the next edge.
        reset_pulse();
        p1_x = 10'd100; p1_y = 10'd100; p1_dir = 2'b01;
        p2_x = 10'd300; p2_y = 10'd400; p2_dir = 2'b11;
        exp_grant(0, 0, 100, 100, 1);
        exp_grant(1, 1, 300, 400, 3);
        exp_grant(0, 2, 100, 100, 1);
        exp_grant(1, 3, 300, 400, 3);
        fire_req = 2'b11;
        nacks = 0;
        for (int f = 0; f < 70; f++) begin
            tick();
            if (fire_ack[0]) nacks++;
            if (fire_ack[1]) nacks++;
        end
        chk("t5_nacks", 64'(nacks), 4);
        chk("t5_full", slot_valid, 4'b1111);
        chk("t5_sb_empty", 64'(sb_q.size()), 0);
        hit_clear = 4'b0010;
        tick();
        chk("t5_no_same_edge", fire_ack, 2'b00);
        chk("t5_cleared", slot_valid, 4'b1101);
        hit_clear = '0;
        exp_grant(1, 1, 300, 400, 3);
        tick();
        chk("t5_next_edge", fire_ack, 2'b10);
        chk("t5_refilled", slot_valid, 4'b1111);
        chk("t5_sb_done", 64'(sb_q.size()), 0);

        // Three live shells, both cooldowns running, then asynchronous reset.
        fire_req  = 2'b01;
        hit_clear = 4'b0001;
        tick();
        chk("t6_capped", fire_ack, 2'b00);
        chk("t6_valid_a", slot_valid, 4'b1110);
        hit_clear = 4'b0100;
        exp_grant(0, 0, 100, 100, 1);
        tick();
        chk("t6_ack", fire_ack, 2'b01);
        chk("t6_valid_b", slot_valid, 4'b1011);
        chk("t6_cd_both", cooldown_active, 2'b11);
        hit_clear = '0;
        fire_req  = 2'b00;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", slot_valid, 0);
        chk("t6_rst_ack", fire_ack, 0);
        chk("t6_rst_cd", cooldown_active, 0);
        #3;
        Reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shell_scheduler.md
Name: shell_scheduler

Overview:
Shared projectile-slot scheduler for the two-player tank game. Accepts fire requests from both tank controllers and allocates shells from a fixed pool of NUM_SLOTS slots. Arbitrates round-robin when slots are scarce, enforces a per-player cooldown and a per-player shell cap, and advances and retires live shells once per frame. Feeds slot positions to the sprite/colour mapper. Takes retire requests from the collision logic.

Parameters:
NUM_SLOTS, 4, shell pool size; power of two, 2..8
SHELL_STEP, 4, pixels moved per frame_clk along shell direction
COOLDOWN, 30, frames after a grant before the same player may fire again
PLAYER_CAP, 2, max live shells owned by one player
X_MIN, 1, leftmost legal shell X
X_MAX, 639, rightmost legal shell X
Y_MIN, 1, topmost legal shell Y
Y_MAX, 479, bottommost legal shell Y

Ports:
frame_clk  in  1  single clock, one edge per video frame
Reset_n  in  1  asynchronous, active-low reset
fire_req  in  2  level request; bit0 = P1, bit1 = P2
p1_x, p1_y  in  10 each  P1 tank centre
p1_dir  in  2  P1 facing: 00 left, 01 right, 10 down, 11 up
p2_x, p2_y  in  10 each  P2 tank centre
p2_dir  in  2  P2 facing, same encoding
hit_clear  in  NUM_SLOTS  per-slot retire request from collision logic
fire_ack  out  2  one-cycle pulse per player on grant
slot_valid  out  NUM_SLOTS  slot holds a live shell
slot_owner  out  NUM_SLOTS  0 = P1, 1 = P2; meaningful only when valid
slot_dir  out  2*NUM_SLOTS  packed per-slot direction, slot i at [2i+1:2i]
slot_x, slot_y  out  10*NUM_SLOTS each  packed per-slot position, slot i at [10i+9:10i]
cooldown_active  out  2  player cooldown counter nonzero

Behaviour:
- Reset (Reset_n low, async): all slot_valid/owner/dir/x/y = 0. fire_ack = 0. Both cooldown counters = 0. RR pointer = P1. All outputs registered.
- Per frame_clk, every live slot is evaluated in this priority order:
  1. hit_clear[i]=1 -> valid cleared. hit_clear on an invalid slot is ignored.
  2. Else, next step leaves bounds -> valid cleared, position held. Bound tests are done before any arithmetic, so there is no 10-bit wrap:
     - left: x < X_MIN+SHELL_STEP
     - right: x+SHELL_STEP > X_MAX
     - up: y < Y_MIN+SHELL_STEP
     - down: y+SHELL_STEP > Y_MAX
  3. Else the shell moves SHELL_STEP in its direction.
- Eligibility: player p is eligible when all of these hold: fire_req[p]=1, cooldown[p]=0, and live count owned by p (pre-edge state) < PLAYER_CAP.
- Free slots: a slot is free if it is invalid in the pre-edge state. Slots retired on this edge are not reusable until the next edge.
- Allocation, lowest free index first:
  - Both eligible, ≥2 free: P1 gets the lowest free slot, P2 the next. RR pointer unchanged.
  - Both eligible, 1 free: the player at the RR pointer wins. Pointer moves to the other player. The loser gets no ack and retries next edge if still requesting.
  - One eligible, ≥1 free: that player gets the lowest free slot. Pointer moves to the other player.
  - No free slot: no grant, no ack, pointer unchanged.
- Granted slot: valid=1, owner=p, dir=p_dir, x/y = tank centre sampled on the grant edge. The first move happens on the following edge.
- fire_ack[p]: high for exactly the cycle after a grant edge. A held fire_req yields at most one grant per COOLDOWN+1 frames.
- Cooldown: loaded with COOLDOWN on grant, decrements by 1 per edge, saturates at 0. A player is eligible again on the edge where the counter reads 0.
- Direction change while a shell is live does not affect that shell.
- Reset asserted mid-operation clears everything immediately. Requests held through reset release are treated as fresh on the first edge.

Test Plan:
- Reset, then P1 fire_req for 1 edge at (160,240) dir 01 -> slot0 valid, owner 0, x=160; fire_ack=01 for one cycle; after 5 more edges slot0 x=180.
- P1 holds fire_req 100 frames, no hits -> grants on frames 0 and 31 only (cap 2 reached); third grant only after a shell retires and cooldown=0.
- Slots 0-2 live, P1 and P2 request same edge, pointer=P1 -> P1 gets slot3, pointer=P2. Repeat with one slot freed -> P2 wins.
- Shell dir 00 at x=4 -> retired on next edge (4 < 1+4), x held at 4, no underflow. Shell dir 10 at y=475 -> moves to 479; retires on the following edge.
- hit_clear[1] pulsed while slot1 live and all other slots full, P2 requesting same edge -> slot1 cleared; P2 granted slot1 on the next edge, not the same one.
- Assert Reset_n low mid-flight with 3 live shells and cooldowns nonzero -> all valid=0, ack=0, cooldown_active=00 immediately, without waiting for a clock edge.
